// File: rtl/clk_div_pkg.sv
// Shared constants and types for the phase-accumulator rate generator.
// The INC_* values assume a 50 MHz clock and a 40-bit accumulator.
package clk_div_pkg;

   localparam int unsigned ACC_W_DEF   = 40;

   localparam logic [39:0] INC_1HZ     = 40'd21990;
   localparam logic [39:0] INC_60HZ    = 40'd1319414;
   localparam logic [39:0] INC_3600HZ  = 40'd79164837;
   localparam logic [39:0] INC_REFRESH = 40'd16777216;

   typedef enum logic [1:0] {
      RATE_1HZ     = 2'd0,
      RATE_60HZ    = 2'd1,
      RATE_3600HZ  = 2'd2,
      RATE_REFRESH = 2'd3
   } rate_e;

endpackage

// File: rtl/rate_tick_gen_if.sv
// Control and status bundle for rate_tick_gen.
// The master side drives enable, clear and rate request; the slave side is the generator.
interface rate_tick_gen_if #(
   parameter int CNT_W = 6
);
   logic             en;
   logic             sync_clr;
   logic [1:0]       rate_sel;
   logic             slow_clk;
   logic             tick;
   logic [CNT_W-1:0] tick_cnt;
   logic             cnt_wrap;
   logic [1:0]       cur_sel;

   modport master (
      output en, sync_clr, rate_sel,
      input  slow_clk, tick, tick_cnt, cnt_wrap, cur_sel
   );

   modport slave (
      input  en, sync_clr, rate_sel,
      output slow_clk, tick, tick_cnt, cnt_wrap, cur_sel
   );
endinterface

// File: rtl/tick_mod_counter.sv
// Modulo-CNT_MOD counter advanced by a one-cycle tick strobe.
// Also used by the clock-display logic, so it carries no rate knowledge.
module tick_mod_counter #(
   parameter  int CNT_MOD = 60,
   localparam int CNT_W   = $clog2(CNT_MOD)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             sync_clr,
   output logic [CNT_W-1:0] tick_cnt,
   output logic             cnt_wrap
);

   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MOD - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_top;

   if (CNT_MOD < 2) begin : g_bad_mod
      $error("tick_mod_counter: CNT_MOD must be at least 2");
   end

   assign w_at_top = (r_cnt == CNT_TOP);

   // Count ticks, folding back to zero after CNT_MOD-1; a clear restarts at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (sync_clr) begin
         r_cnt <= '0;
      end else if (tick) begin
         r_cnt <= w_at_top ? '0 : r_cnt + 1'b1;
      end
   end

   assign tick_cnt = r_cnt;
   assign cnt_wrap = tick & w_at_top;

endmodule

// File: rtl/rate_tick_gen.sv
// Phase-accumulator rate generator: slow square wave, tick strobe and modulo tick count.
// Rate requests are only adopted on accumulator wrap so a slow_clk period never mixes rates.
module rate_tick_gen
   import clk_div_pkg::*;
#(
   parameter  int               ACC_W   = 40,
   parameter  logic [ACC_W-1:0] INC0    = ACC_W'(INC_1HZ),
   parameter  logic [ACC_W-1:0] INC1    = ACC_W'(INC_60HZ),
   parameter  logic [ACC_W-1:0] INC2    = ACC_W'(INC_3600HZ),
   parameter  logic [ACC_W-1:0] INC3    = ACC_W'(INC_REFRESH),
   parameter  int               CNT_MOD = 60,
   localparam int               CNT_W   = $clog2(CNT_MOD)
) (
   input  logic            clk,
   input  logic            reset,
   rate_tick_gen_if.slave  bus
);

   logic [ACC_W-1:0] r_acc;
   logic             r_msb_q;
   rate_e            r_cur_sel;

   logic [ACC_W-1:0] w_inc;
   logic [ACC_W-1:0] w_sum;
   logic             w_carry;
   logic             w_tick;
   logic [CNT_W-1:0] w_tick_cnt;
   logic             w_cnt_wrap;

   // An increment of zero never ticks; one with the MSB set aliases and breaks 50% duty.
   if ((INC0 == '0) || INC0[ACC_W-1] || (INC1 == '0) || INC1[ACC_W-1] ||
       (INC2 == '0) || INC2[ACC_W-1] || (INC3 == '0) || INC3[ACC_W-1]) begin : g_bad_inc
      $error("rate_tick_gen: every INCx must be nonzero and below 2^(ACC_W-1)");
   end

   // Select the increment for the rate currently in effect.
   always_comb begin
      w_inc = INC0;
      case (r_cur_sel)
         RATE_1HZ:     w_inc = INC0;
         RATE_60HZ:    w_inc = INC1;
         RATE_3600HZ:  w_inc = INC2;
         RATE_REFRESH: w_inc = INC3;
         default:      w_inc = INC0;
      endcase
   end

   assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, w_inc};

   // Advance the accumulator; adopt a new rate only on the wrapping edge.
   // msb_q follows the MSB on every edge, so a pause can never stretch a tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc     <= '0;
         r_msb_q   <= 1'b0;
         r_cur_sel <= RATE_1HZ;
      end else if (bus.sync_clr) begin
         r_acc     <= '0;
         r_msb_q   <= 1'b0;
         r_cur_sel <= rate_e'(bus.rate_sel);
      end else begin
         r_msb_q <= r_acc[ACC_W-1];
         if (bus.en) begin
            r_acc <= w_sum;
            if (w_carry) begin
               r_cur_sel <= rate_e'(bus.rate_sel);
            end
         end
      end
   end

   assign w_tick = r_acc[ACC_W-1] & ~r_msb_q;

   tick_mod_counter #(
      .CNT_MOD (CNT_MOD)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .tick     (w_tick),
      .sync_clr (bus.sync_clr),
      .tick_cnt (w_tick_cnt),
      .cnt_wrap (w_cnt_wrap)
   );

   assign bus.slow_clk = r_acc[ACC_W-1];
   assign bus.tick     = w_tick;
   assign bus.tick_cnt = w_tick_cnt;
   assign bus.cnt_wrap = w_cnt_wrap;
   assign bus.cur_sel  = r_cur_sel;

endmodule
